i2s_capture: RTL and testbench
==============================

I2S_CAPTURE -- requirements
Module: i2s_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16: captured sample width, MSB-first.
REQ-002 SHALL have parameter ADDR_W, default 8: audio RAM word-address width.
REQ-003 SHALL have port ck  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  capture enable, ck domain.
REQ-006 SHALL have port sck  input  1  I2S bit clock, asynchronous, at most ck/4.
REQ-007 SHALL have port ws  input  1  I2S word select: 0 = left, 1 = right.
REQ-008 SHALL have port sd  input  1  I2S serial data.
REQ-009 SHALL have port wr_en  output  1  audio RAM write request.
REQ-010 SHALL have port wr_ready  input  1  audio RAM accepts the write this cycle.
REQ-011 SHALL have port wr_addr  output  ADDR_W  audio RAM word address.
REQ-012 SHALL have port wr_data  output  WIDTH  sample, raw two's complement.
REQ-013 SHALL have port frame  output  1  one-ck pulse on stereo frame complete.
REQ-014 SHALL have port frame_ptr  output  ADDR_W-1  index of the last completed frame.
REQ-015 SHALL have port overrun  output  1  sticky sample-dropped flag.
REQ-016 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-017 SHALL pass sck, ws and sd through two-flop synchronisers before use.
REQ-018 SHALL act on an sck rise event: synchronised sck was 0 last cycle and is 1 now; sd and ws are sampled only on that event.
REQ-019 SHALL use capture states IDLE, WAIT_LEFT and CAPTURE.
REQ-020 SHALL hold IDLE while enable=0, discard any partial word, and move to WAIT_LEFT on the first cycle with enable=1.
REQ-021 SHALL leave WAIT_LEFT for CAPTURE only on a ws 1->0 transition seen at a rise event, so every frame starts with left.
REQ-022 In CAPTURE, on any rise event where ws differs from the previous sampled ws, SHALL do three things:
  - discard the bit sampled on that event (I2S one-bit delay);
  - clear the bit count;
  - set the channel to the new ws value.
REQ-023 On the next WIDTH rise events SHALL shift sd in MSB-first; after WIDTH bits, the word is complete and further bits in the slot are ignored.
REQ-024 If ws changes before WIDTH bits are captured, SHALL discard the partial word with no write and no overrun.
REQ-025 On completion SHALL load a one-deep pending register with the data and wr_addr = {wptr, chan}.
  - wptr is an (ADDR_W-1)-bit frame counter.
  - Left goes to even addresses, right to odd.
REQ-026 SHALL assert wr_en the cycle after the pending load and hold wr_en, wr_addr and wr_data stable until a cycle with wr_en=1 and wr_ready=1.
REQ-027 The transfer SHALL complete in the wr_en=1, wr_ready=1 cycle; wr_en SHALL drop the next cycle unless a new word is pending.
REQ-028 If a word completes while the pending register is still occupied, SHALL drop the new word, keep the old one, and set overrun.
REQ-029 After a right-channel transfer SHALL pulse frame for exactly one ck on the following cycle, load frame_ptr with wptr, and increment wptr.
REQ-030 wptr SHALL wrap from 2^(ADDR_W-1)-1 to 0 with no flag.
REQ-031 If overrun_clr and a new overrun event occur in the same cycle, overrun SHALL remain set.
REQ-032 Deasserting enable SHALL NOT cancel an already pending write; that write SHALL complete normally.
REQ-033 A dropped right-channel word SHALL NOT advance wptr or pulse frame.

Reset
REQ-034 While rst=1 SHALL, asynchronously:
  - force state IDLE;
  - drive wr_en=0, wr_addr=0, wr_data=0, frame=0, frame_ptr=0, overrun=0;
  - clear wptr, bit count, pending register and synchronisers.
REQ-035 Reset asserted mid-word or mid-write SHALL abandon the operation with no further wr_en.
REQ-036 After rst falls SHALL resume in IDLE and follow REQ-020.

Verification
REQ-037 Setup: ck period 84 ns, sck period 672 ns, enable=1, wr_ready=1, WIDTH=16.
  - Stimulus: send left 0x1111 then right 0xEEEE.
  - Response: writes (addr 0, 0x1111) then (addr 1, 0xEEEE), one frame pulse, frame_ptr=0.
REQ-038 Stimulus: start enable mid-right-slot, then send one full frame.
  - Response: the partial right word is not written; first write is left to addr 0.
REQ-039 Stimulus: hold wr_ready=0 across the left-word completion and the right-word completion.
  - Response: wr_en held with addr 0 and data stable; overrun=1; the right word is not written.
  - Then set overrun_clr=1: overrun=0.
REQ-040 Setup: ADDR_W=3.
  - Stimulus: send 5 frames.
  - Response: frame 4 writes to addrs 0 and 1; frame_ptr sequence is 0,1,2,3,0.
REQ-041 Stimulus: assert rst while the 8th bit is being shifted in and while wr_en=1.
  - Response: all outputs are 0 immediately.
  - After release, no write occurs until the next ws 1->0 transition.
REQ-042 Stimulus: use a 20-bit slot with WIDTH=16, and a 10-bit truncated slot.
  - Response: the 20-bit slot yields its upper 16 bits; the truncated slot produces no write and no overrun.

Source files
------------

// File: rtl/i2s_capture.sv
`default_nettype none
// i2s_capture: I2S receiver that writes left/right samples to an audio RAM as {frame, chan} word pairs.
// Revision: 1.0

module i2s_capture #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              enable,
   input  logic              sck,
   input  logic              ws,
   input  logic              sd,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              frame,
   output logic [ADDR_W-2:0] frame_ptr,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = ADDR_W - 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_LEFT = 2'd1,
      S_CAPTURE   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_sck_s1, r_sck_s2, r_sck_d;
   logic              r_ws_s1, r_ws_s2;
   logic              r_sd_s1, r_sd_s2;
   logic              r_prev_ws;
   logic              r_chan;
   logic [CNT_W-1:0]  r_bitcnt;
   logic [WIDTH-1:0]  r_shift;
   logic [PW-1:0]     r_wptr;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [WIDTH-1:0]  r_wr_data;
   logic              r_frame;
   logic [PW-1:0]     r_frame_ptr;
   logic              r_overrun;

   logic              w_rise;
   logic              w_ws_edge;
   logic [WIDTH-1:0]  w_word;
   logic              w_done;
   logic              w_xfer;
   logic              w_busy;
   logic              w_load;
   logic              w_drop;
   logic [PW-1:0]     w_wptr_nxt;

   assign w_rise    = r_sck_s2 & ~r_sck_d;
   assign w_ws_edge = (r_ws_s2 != r_prev_ws);
   assign w_word    = {r_shift[WIDTH-2:0], r_sd_s2};
   assign w_done    = (r_state == S_CAPTURE) && enable && w_rise && !w_ws_edge &&
                      (r_bitcnt == CNT_W'(WIDTH - 1));
   assign w_xfer    = r_wr_en & wr_ready;
   // The output register doubles as the one-deep pending slot; it frees up in its handshake cycle.
   assign w_busy    = r_wr_en & ~wr_ready;
   assign w_load    = w_done & ~w_busy;
   assign w_drop    = w_done & w_busy;
   assign w_wptr_nxt = r_wptr + PW'(w_xfer && r_wr_addr[0]);

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sck_s1    <= 1'b0;
         r_sck_s2    <= 1'b0;
         r_sck_d     <= 1'b0;
         r_ws_s1     <= 1'b0;
         r_ws_s2     <= 1'b0;
         r_sd_s1     <= 1'b0;
         r_sd_s2     <= 1'b0;
         r_prev_ws   <= 1'b0;
         r_chan      <= 1'b0;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_wptr      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_frame     <= 1'b0;
         r_frame_ptr <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_sck_s1 <= sck;
         r_sck_s2 <= r_sck_s1;
         r_sck_d  <= r_sck_s2;
         r_ws_s1  <= ws;
         r_ws_s2  <= r_ws_s1;
         r_sd_s1  <= sd;
         r_sd_s2  <= r_sd_s1;
         r_frame  <= 1'b0;

         if (w_rise) begin
            r_prev_ws <= r_ws_s2;
         end

         case (r_state)
            S_IDLE: begin
               r_bitcnt <= '0;
               if (enable) begin
                  r_state <= S_WAIT_LEFT;
               end
            end
            S_WAIT_LEFT: begin
               if (!enable) begin
                  r_state <= S_IDLE;
               end else if (w_rise && r_prev_ws && !r_ws_s2) begin
                  r_state  <= S_CAPTURE;
                  r_chan   <= 1'b0;
                  r_bitcnt <= '0;
               end
            end
            S_CAPTURE: begin
               if (!enable) begin
                  r_state  <= S_IDLE;
                  r_bitcnt <= '0;
               end else if (w_rise) begin
                  if (w_ws_edge) begin
                     // The bit under a ws change belongs to the previous word and is dropped.
                     r_bitcnt <= '0;
                     r_chan   <= r_ws_s2;
                  end else if (r_bitcnt != CNT_W'(WIDTH)) begin
                     r_shift  <= w_word;
                     r_bitcnt <= r_bitcnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_xfer) begin
            r_wr_en <= 1'b0;
            if (r_wr_addr[0]) begin
               r_frame     <= 1'b1;
               r_frame_ptr <= r_wptr;
               r_wptr      <= w_wptr_nxt;
            end
         end

         if (w_load) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {w_wptr_nxt, r_chan};
            r_wr_data <= w_word;
         end

         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign frame     = r_frame;
   assign frame_ptr = r_frame_ptr;
   assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_capture.sv
`default_nettype none
// tb_i2s_capture: directed bench for i2s_capture with a default instance and an ADDR_W=3 instance.
// Revision: 1.0

module tb_i2s_capture;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        sck = 1'b0;
   logic        ws = 1'b0;
   logic        sd = 1'b0;
   logic        wr_ready = 1'b1;
   logic        overrun_clr = 1'b0;

   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame;
   logic [6:0]  frame_ptr;
   logic        overrun;

   logic        wr_en3;
   logic [2:0]  wr_addr3;
   logic [15:0] wr_data3;
   logic        frame3;
   logic [1:0]  frame_ptr3;
   logic        overrun3;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  wa_q[$];
   logic [15:0] wd_q[$];
   logic [6:0]  fp_q[$];
   logic [2:0]  wa3_q[$];
   logic [15:0] wd3_q[$];
   logic [1:0]  fp3_q[$];

   i2s_capture #(.WIDTH(16), .ADDR_W(8)) u_dut (
      .ck(ck), .rst(rst), .enable(enable), .sck(sck), .ws(ws), .sd(sd),
      .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame(frame), .frame_ptr(frame_ptr), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   i2s_capture #(.WIDTH(16), .ADDR_W(3)) u_dut3 (
      .ck(ck), .rst(rst), .enable(enable), .sck(sck), .ws(ws), .sd(sd),
      .wr_en(wr_en3), .wr_ready(wr_ready), .wr_addr(wr_addr3), .wr_data(wr_data3),
      .frame(frame3), .frame_ptr(frame_ptr3), .overrun(overrun3), .overrun_clr(overrun_clr)
   );

   always #42 ck = ~ck;

   // ck-domain inputs change at posedge+1, so the negedge sees a whole handshake cycle.
   always @(negedge ck) begin
      if (wr_en && wr_ready) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (frame) fp_q.push_back(frame_ptr);
      if (wr_en3 && wr_ready) begin
         wa3_q.push_back(wr_addr3);
         wd3_q.push_back(wr_data3);
      end
      if (frame3) fp3_q.push_back(frame_ptr3);
   end

   function automatic logic [31:0] qa(input int i);
      return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] qd(input int i);
      return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] qf(input int i);
      return (i < fp_q.size()) ? 32'(fp_q[i]) : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] qa3(input int i);
      return (i < wa3_q.size()) ? 32'(wa3_q[i]) : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] qd3(input int i);
      return (i < wd3_q.size()) ? 32'(wd3_q[i]) : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [31:0] qf3(input int i);
      return (i < fp3_q.size()) ? 32'(fp3_q[i]) : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_q();
      wa_q.delete(); wd_q.delete(); fp_q.delete();
      wa3_q.delete(); wd3_q.delete(); fp3_q.delete();
   endtask

   // One I2S bit: data changes while sck is low, receiver samples on the rise.
   task automatic send_bit(input logic w, input logic d);
      sck = 1'b0; ws = w; sd = d;
      #336;
      sck = 1'b1;
      #336;
   endtask

   task automatic send_slot(input logic c, input logic [31:0] data, input int n);
      send_bit(c, 1'b0);
      for (int i = n - 1; i >= 0; i--) send_bit(c, data[i]);
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      send_slot(1'b0, 32'(l), 16);
      send_slot(1'b1, 32'(r), 16);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; wr_ready = 1'b1; overrun_clr = 1'b0;
      repeat (3) @(posedge ck);
      #1 rst = 1'b0;
      clear_q();
      @(posedge ck);
      #1 enable = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge ck);
      chk("rst_wr_en", 32'(wr_en), 32'h0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);
      chk("rst_wr_data", 32'(wr_data), 32'h0);
      chk("rst_frame_ptr", 32'(frame_ptr), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);

      // Basic stereo frame
      do_reset();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_frame(16'h1111, 16'hEEEE);
      repeat (6) @(negedge ck);
      chk("basic_nwr", 32'(wa_q.size()), 32'd2);
      chk("basic_a0", qa(0), 32'h0);
      chk("basic_d0", qd(0), 32'h1111);
      chk("basic_a1", qa(1), 32'h1);
      chk("basic_d1", qd(1), 32'hEEEE);
      chk("basic_nframe", 32'(fp_q.size()), 32'd1);
      chk("basic_fptr", qf(0), 32'h0);
      chk("basic_fptr_out", 32'(frame_ptr), 32'h0);

      // Enable mid right slot
      do_reset();
      enable = 1'b0;
      send_bit(1'b1, 1'b0);
      send_slot(1'b0, 32'hFFFF, 16);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      @(posedge ck);
      #1 enable = 1'b1;
      for (int i = 0; i < 17; i++) send_bit(1'b1, 1'b1);
      send_frame(16'hA5A5, 16'h5A5A);
      repeat (6) @(negedge ck);
      chk("late_en_nwr", 32'(wa_q.size()), 32'd2);
      chk("late_en_a0", qa(0), 32'h0);
      chk("late_en_d0", qd(0), 32'hA5A5);
      chk("late_en_d1", qd(1), 32'h5A5A);

      // Backpressure and overrun
      do_reset();
      @(posedge ck);
      #1 wr_ready = 1'b0;
      send_bit(1'b1, 1'b0);
      send_frame(16'h1234, 16'h5678);
      repeat (4) @(negedge ck);
      chk("bp_wr_en", 32'(wr_en), 32'h1);
      chk("bp_addr", 32'(wr_addr), 32'h0);
      chk("bp_data", 32'(wr_data), 32'h1234);
      chk("bp_overrun", 32'(overrun), 32'h1);
      chk("bp_nwr", 32'(wa_q.size()), 32'd0);
      @(posedge ck);
      #1 wr_ready = 1'b1;
      repeat (3) @(negedge ck);
      chk("bp_after_nwr", 32'(wa_q.size()), 32'd1);
      chk("bp_after_d0", qd(0), 32'h1234);
      chk("bp_after_wr_en", 32'(wr_en), 32'h0);
      chk("bp_no_frame", 32'(fp_q.size()), 32'd0);
      chk("bp_sticky", 32'(overrun), 32'h1);
      @(posedge ck);
      #1 overrun_clr = 1'b1;
      @(posedge ck);
      #1 overrun_clr = 1'b0;
      @(negedge ck);
      chk("ovr_clr", 32'(overrun), 32'h0);

      // Long slot then truncated slot
      do_reset();
      send_bit(1'b1, 1'b0);
      send_slot(1'b0, 32'hABCDE, 20);
      send_slot(1'b1, 32'h3FF, 10);
      send_frame(16'h0F0F, 16'hF0F0);
      repeat (6) @(negedge ck);
      chk("slot_nwr", 32'(wa_q.size()), 32'd3);
      chk("slot_a0", qa(0), 32'h0);
      chk("slot_d0", qd(0), 32'hABCD);
      chk("slot_a1", qa(1), 32'h0);
      chk("slot_d1", qd(1), 32'h0F0F);
      chk("slot_a2", qa(2), 32'h1);
      chk("slot_d2", qd(2), 32'hF0F0);
      chk("slot_overrun", 32'(overrun), 32'h0);
      chk("slot_nframe", 32'(fp_q.size()), 32'd1);

      // Frame pointer wrap on the ADDR_W=3 instance
      do_reset();
      send_bit(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) send_frame(16'h0100 + 16'(k), 16'h0200 + 16'(k));
      repeat (6) @(negedge ck);
      chk("wrap_nwr", 32'(wa3_q.size()), 32'd10);
      chk("wrap_nframe", 32'(fp3_q.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("wrap_aL%0d", k), qa3(2 * k), 32'(2 * (k % 4)));
         chk($sformatf("wrap_aR%0d", k), qa3(2 * k + 1), 32'(2 * (k % 4) + 1));
         chk($sformatf("wrap_dR%0d", k), qd3(2 * k + 1), 32'h0200 + 32'(k));
         chk($sformatf("wrap_fp%0d", k), qf3(k), 32'(k % 4));
      end
      chk("wide_fp4", qf(4), 32'h4);

      // Asynchronous reset mid-word and mid-write
      do_reset();
      @(posedge ck);
      #1 wr_ready = 1'b0;
      send_bit(1'b1, 1'b0);
      send_slot(1'b0, 32'h1357, 16);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
      sck = 1'b0; ws = 1'b1; sd = 1'b1;
      #336;
      sck = 1'b1;
      #100;
      chk("arst_pre_wr_en", 32'(wr_en), 32'h1);
      rst = 1'b1;
      #1;
      chk("arst_wr_en", 32'(wr_en), 32'h0);
      chk("arst_addr", 32'(wr_addr), 32'h0);
      chk("arst_data", 32'(wr_data), 32'h0);
      chk("arst_frame", 32'(frame), 32'h0);
      chk("arst_fptr", 32'(frame_ptr), 32'h0);
      chk("arst_overrun", 32'(overrun), 32'h0);
      #235;
      rst = 1'b0;
      wr_ready = 1'b1;
      clear_q();
      for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
      chk("arst_no_wr", 32'(wa_q.size()), 32'd0);
      send_frame(16'h3C3C, 16'hC3C3);
      repeat (6) @(negedge ck);
      chk("arst_nwr", 32'(wa_q.size()), 32'd2);
      chk("arst_a0", qa(0), 32'h0);
      chk("arst_d0", qd(0), 32'h3C3C);
      chk("arst_d1", qd(1), 32'hC3C3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
